// File: rtl/cpu_isa_pkg.sv
// -----------------------------------------------------------------------------
// cpu_isa_pkg
// Shared ISA definitions for the small CPU: field widths, opcode encodings,
// default address/data widths and the fetch-unit state type.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_isa_pkg;

    localparam int OPCODE_W   = 3;
    localparam int REG_W      = 5;
    localparam int IMM_W      = 16;

    localparam int ISA_ADDR_W = 16;
    localparam int ISA_DATA_W = 32;

    localparam logic [OPCODE_W-1:0] OP_LW   = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_HALT = 3'b111;

    // Fetch unit control state. The HALTED state is also visible on the
    // top-level halted output, which doubles as the state debug signal.
    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_e;

    // Opcode lives in the top OPCODE_W bits of an instruction word.
    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [ISA_DATA_W-1:0] inst);
        return inst[ISA_DATA_W-1 -: OPCODE_W];
    endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// -----------------------------------------------------------------------------
// fetch_skid_fifo
// Small synchronous FIFO holding fetched {instruction, pc} entries between the
// fetch stage and decode.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset (clears storage and outputs)
//   i_push       write i_push_data (ignored when full unless popping)
//   i_push_data  entry to enqueue
//   i_pop        consume head entry (ignored when empty)
//   i_flush      discard all entries; has priority over push/pop
//   o_valid      FIFO holds at least one entry
//   o_full       FIFO holds DEPTH entries
//   o_count      number of stored entries
//   o_head       head entry; when empty, the last popped head (0 after
//                reset/flush) so the outputs never go X
// -----------------------------------------------------------------------------
module fetch_skid_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic                         o_valid,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [WIDTH-1:0]             o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hold;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO can still accept a push when the head leaves the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;
    assign o_head  = w_empty ? r_hold : r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Owns the program counter, drives the word address to a zero-latency
// instruction memory, captures {instruction, pc} into a skid FIFO and hands
// entries to decode. Handles redirects, HALT and back-pressure.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   inst_address     word address to instruction memory (the pc register)
//   read_data        instruction returned combinationally for inst_address
//   redirect_valid   load redirect_pc, flush FIFO, return to RUN
//   redirect_pc      redirect target word address
//   stall_fetch      hold pc/state and suppress capture
//   out_valid/out_ready/out_inst/out_pc  decode-side handshake
//   halted           unit is in the HALTED state
//
// Handshake: an entry transfers on a rising edge where out_valid && out_ready.
// While out_valid && !out_ready, out_inst/out_pc are held stable. out_valid
// never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import cpu_isa_pkg::*;
#(
    parameter int                   ADDR_W      = ISA_ADDR_W,
    parameter int                   DATA_W      = ISA_DATA_W,
    parameter logic [ADDR_W-1:0]    RESET_PC    = '0,
    parameter int                   FIFO_DEPTH  = 2,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = OP_HALT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] inst_address,
    input  logic [DATA_W-1:0] read_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall_fetch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);

    localparam int ENTRY_W = DATA_W + ADDR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_next_pc;

    logic               w_fifo_valid;
    logic               w_fifo_full;
    logic [CNT_W-1:0]   w_fifo_count;
    logic [ENTRY_W-1:0] w_fifo_head;
    logic               w_pop;
    logic               w_fetch_fire;
    logic               w_is_halt;

    assign w_pop     = w_fifo_valid && out_ready;
    assign w_is_halt = (read_data[DATA_W-1 -: OPCODE_W] == HALT_OPCODE);

    // Capture only in RUN, when not frozen or redirected, and when a slot is
    // free now or is being freed by the consumer this same edge.
    assign w_fetch_fire = (r_state == FS_RUN) && !stall_fetch && !redirect_valid &&
                          (!w_fifo_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FS_RUN;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        if (redirect_valid) begin
            w_next_state = FS_RUN;
            w_next_pc    = redirect_pc;
        end else if (w_fetch_fire) begin
            if (w_is_halt) begin
                // The HALT word is enqueued but pc stays on it.
                w_next_state = FS_HALTED;
            end else begin
                w_next_pc = r_pc + ADDR_W'(1);
            end
        end
    end

    fetch_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_fetch_fire),
        .i_push_data ({read_data, r_pc}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_valid     (w_fifo_valid),
        .o_full      (w_fifo_full),
        .o_count     (w_fifo_count),
        .o_head      (w_fifo_head)
    );

    assign inst_address = r_pc;
    assign out_valid    = w_fifo_valid;
    assign out_inst     = w_fifo_head[ENTRY_W-1 -: DATA_W];
    assign out_pc       = w_fifo_head[ADDR_W-1:0];
    assign halted       = (r_state == FS_HALTED);

    // Count is only needed inside the FIFO for full detection; keep it
    // observable for debug probes without leaving it dangling.
    logic w_unused_count;
    assign w_unused_count = ^w_fifo_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst_address;
    logic [31:0] read_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        stall_fetch;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [15:0] out_pc;
    logic        halted;

    int n_cmp;
    int n_err;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_address   (inst_address),
        .read_data      (read_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_fetch    (stall_fetch),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    // ---------------- instruction memory model ----------------
    function automatic logic [31:0] imem(input logic [15:0] a);
        case (a)
            16'd0:   return 32'h070000FF;
            16'd1:   return 32'h06000008;
            16'd7:   return 32'hA80A0000;
            16'd11:  return 32'h820C1000;
            16'd12:  return 32'hE0000000;
            default: return 32'h00000000;
        endcase
    endfunction

    assign read_data = imem(inst_address);

    // ---------------- helpers ----------------
    // Advance one rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        stall_fetch    = 1'b0;
        out_ready      = 1'b1;

        // Reset state
        tick(2);
        check("rst_addr",   32'(inst_address), 32'h0000);
        check("rst_valid",  32'(out_valid),    32'd0);
        check("rst_inst",   out_inst,          32'h00000000);
        check("rst_pc",     32'(out_pc),       32'h0000);
        check("rst_halted", 32'(halted),       32'd0);

        // Streaming with out_ready=1
        rst_n = 1'b1;
        tick(1);
        check("s1_valid", 32'(out_valid),    32'd1);
        check("s1_inst",  out_inst,          32'h070000FF);
        check("s1_pc",    32'(out_pc),       32'h0000);
        check("s1_addr",  32'(inst_address), 32'h0001);
        tick(1);
        check("s2_inst",  out_inst,          32'h06000008);
        check("s2_pc",    32'(out_pc),       32'h0001);
        check("s2_addr",  32'(inst_address), 32'h0002);
        tick(1);
        check("s3_pc",    32'(out_pc),       32'h0002);
        check("s3_addr",  32'(inst_address), 32'h0003);

        // Back-pressure from reset
        rst_n     = 1'b0;
        out_ready = 1'b0;
        tick(1);
        check("bp_rst_addr",  32'(inst_address), 32'h0000);
        check("bp_rst_valid", 32'(out_valid),    32'd0);
        rst_n = 1'b1;
        tick(3);
        check("bp_addr_hold", 32'(inst_address), 32'h0002);
        check("bp_inst_hold", out_inst,          32'h070000FF);
        check("bp_pc_hold",   32'(out_pc),       32'h0000);
        tick(1);
        check("bp_addr_hold2", 32'(inst_address), 32'h0002);
        check("bp_inst_hold2", out_inst,          32'h070000FF);
        out_ready = 1'b1;
        tick(1);
        check("bp_d1_inst", out_inst,    32'h06000008);
        check("bp_d1_pc",   32'(out_pc), 32'h0001);
        tick(1);
        check("bp_d2_inst", out_inst,    32'h00000000);
        check("bp_d2_pc",   32'(out_pc), 32'h0002);

        // Redirect to 7 while FIFO is full
        out_ready = 1'b0;
        tick(1);
        check("rd7_pre_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'd7;
        tick(1);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("rd7_flush_valid", 32'(out_valid),    32'd0);
        check("rd7_addr",        32'(inst_address), 32'h0007);
        check("rd7_flush_inst",  out_inst,          32'h00000000);
        tick(1);
        check("rd7_valid", 32'(out_valid), 32'd1);
        check("rd7_inst",  out_inst,       32'hA80A0000);
        check("rd7_pc",    32'(out_pc),    32'h0007);
        tick(1);
        check("rd7_next_pc", 32'(out_pc), 32'h0008);

        // Redirect to 11, run into HALT at 12
        redirect_valid = 1'b1;
        redirect_pc    = 16'd11;
        tick(1);
        redirect_valid = 1'b0;
        check("rd11_flush_valid", 32'(out_valid), 32'd0);
        tick(1);
        check("rd11_inst", out_inst,          32'h820C1000);
        check("rd11_pc",   32'(out_pc),       32'h000B);
        check("rd11_addr", 32'(inst_address), 32'h000C);
        tick(1);
        check("halt_inst",   out_inst,          32'hE0000000);
        check("halt_pc",     32'(out_pc),       32'h000C);
        check("halt_flag",   32'(halted),       32'd1);
        check("halt_addr",   32'(inst_address), 32'h000C);
        tick(1);
        check("halt_drained",   32'(out_valid),    32'd0);
        check("halt_hold_inst", out_inst,          32'hE0000000);
        check("halt_flag2",     32'(halted),       32'd1);
        tick(1);
        check("halt_still_empty", 32'(out_valid),    32'd0);
        check("halt_addr2",       32'(inst_address), 32'h000C);

        // Redirect to 0 resumes
        redirect_valid = 1'b1;
        redirect_pc    = 16'd0;
        tick(1);
        redirect_valid = 1'b0;
        check("resume_halted", 32'(halted),       32'd0);
        check("resume_addr",   32'(inst_address), 32'h0000);
        check("resume_valid0", 32'(out_valid),    32'd0);
        tick(1);
        check("resume_valid", 32'(out_valid), 32'd1);
        check("resume_inst",  out_inst,       32'h070000FF);
        check("resume_pc",    32'(out_pc),    32'h0000);

        // Redirect to FFFF, PC wraps
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        tick(1);
        redirect_valid = 1'b0;
        tick(1);
        check("wrap_pc_ffff", 32'(out_pc),       32'h0000FFFF);
        check("wrap_inst0",   out_inst,          32'h00000000);
        check("wrap_addr",    32'(inst_address), 32'h0000);
        tick(1);
        check("wrap_pc_0",  32'(out_pc),       32'h0000);
        check("wrap_inst",  out_inst,          32'h070000FF);
        check("wrap_addr1", 32'(inst_address), 32'h0001);

        // Stall: pops continue, no capture, pc holds
        stall_fetch = 1'b1;
        tick(1);
        check("stall_valid", 32'(out_valid),    32'd0);
        check("stall_addr",  32'(inst_address), 32'h0001);

        // Reset overrides stall and redirect
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'd7;
        tick(1);
        check("rst2_valid",  32'(out_valid),    32'd0);
        check("rst2_addr",   32'(inst_address), 32'h0000);
        check("rst2_halted", 32'(halted),       32'd0);
        check("rst2_inst",   out_inst,          32'h00000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
